// File: rtl/raytrace_pkg.sv
// Shared types and helpers for the primary-ray generator: camera vector layout,
// FSM state encoding and lane access for packed {z,y,x} vectors.
package raytrace_pkg;

    localparam int RG_COORD_W   = 11;
    localparam int RG_DIM_W     = 13;
    localparam int RG_DIR_W     = 32;
    localparam int RG_IDX_W     = 32;
    localparam int RG_MAX_CORES = 8;

    typedef logic signed [RG_COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t z;
        coord_t y;
        coord_t x;
    } vec3_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } rg_state_t;

    function automatic vec3_t unpack_vec(input logic [3*RG_COORD_W-1:0] flat);
        return vec3_t'(flat);
    endfunction

    function automatic logic [3*RG_COORD_W-1:0] pack_vec(input vec3_t v);
        return v;
    endfunction

    // Lane 0 is x, lane 1 is y, lane 2 is z.
    function automatic coord_t get_lane(input vec3_t v, input int unsigned i);
        case (i)
            0:       return v.x;
            1:       return v.y;
            default: return v.z;
        endcase
    endfunction

endpackage

// File: rtl/ray_pixel_counter.sv
// Strided pixel walker: steps x/y/idx by num_cores without division, flags the
// final pixel of this core's share and stops once it has been issued.
module ray_pixel_counter
    import raytrace_pkg::*;
#(
    parameter int DIM_W  = RG_DIM_W,
    parameter int IDX_W  = RG_IDX_W,
    parameter int CORE_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              clear,
    input  logic              en,
    input  logic [CORE_W-1:0] core_id,
    input  logic [CORE_W-1:0] num_cores,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [IDX_W-1:0]  total,
    output logic              pix_valid,
    output logic [DIM_W-1:0]  x,
    output logic [DIM_W-1:0]  y,
    output logic [IDX_W-1:0]  idx,
    output logic              last
);

    logic [DIM_W:0]   x_sum;
    logic [DIM_W:0]   w_ext;
    logic [IDX_W-1:0] idx_sum;

    assign x_sum   = {1'b0, x} + (DIM_W+1)'(num_cores);
    assign w_ext   = {1'b0, img_w};
    assign idx_sum = idx + IDX_W'(num_cores);
    assign last    = (idx_sum >= total);

    // num_cores never exceeds the width, so one conditional subtract wraps x.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_valid <= 1'b0;
            x         <= '0;
            y         <= '0;
            idx       <= '0;
        end else if (clear) begin
            pix_valid <= 1'b0;
        end else if (load) begin
            pix_valid <= 1'b1;
            x         <= DIM_W'(core_id);
            y         <= '0;
            idx       <= IDX_W'(core_id);
        end else if (en && pix_valid) begin
            idx <= idx_sum;
            if (x_sum >= w_ext) begin
                x <= DIM_W'(x_sum - w_ext);
                y <= y + 1'b1;
            end else begin
                x <= x_sum[DIM_W-1:0];
            end
            if (last) begin
                pix_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ray_gen_stream.sv
// Streaming primary-ray generator for one core of an interleaved frame render:
// config check/latch, pixel walk, offset stage, 3-lane MAC and a valid/ready output register.
module ray_gen_stream
    import raytrace_pkg::*;
#(
    parameter int  COORD_W   = RG_COORD_W,
    parameter int  DIM_W     = RG_DIM_W,
    parameter int  DIR_W     = RG_DIR_W,
    parameter int  IDX_W     = RG_IDX_W,
    parameter int  MAX_CORES = RG_MAX_CORES,
    localparam int CORE_W    = $clog2(MAX_CORES+1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [3*COORD_W-1:0] cam_fwd,
    input  logic [3*COORD_W-1:0] cam_right,
    input  logic [3*COORD_W-1:0] cam_up,
    input  logic [DIM_W-1:0]     img_w,
    input  logic [DIM_W-1:0]     img_h,
    input  logic [CORE_W-1:0]    core_id,
    input  logic [CORE_W-1:0]    num_cores,
    output logic                 ray_valid,
    input  logic                 ray_ready,
    output logic [3*DIR_W-1:0]   ray_dir,
    output logic [IDX_W-1:0]     ray_index,
    output logic                 ray_last,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    localparam int PROD_W = COORD_W + DIM_W + 1;
    localparam int SUM_W  = (PROD_W + 2 > DIR_W) ? PROD_W + 2 : DIR_W;

    rg_state_t state_reg, state_next;

    logic [2*DIM_W-1:0] area;
    logic               cfg_ok;
    logic               accept;
    logic               reject;
    logic               adv;
    logic               finish;

    logic [DIM_W-1:0]   w_reg, h_reg;
    logic [CORE_W-1:0]  nc_reg;
    logic [IDX_W-1:0]   total_reg;
    vec3_t              fwd_reg, right_reg, up_reg;

    logic               pix_valid, pix_last;
    logic [DIM_W-1:0]   pix_x, pix_y;
    logic [IDX_W-1:0]   pix_idx;

    logic               s1_valid_reg, s1_last_reg;
    logic signed [DIM_W:0] dx_reg, dy_reg;
    logic [IDX_W-1:0]   s1_idx_reg;

    logic               ray_valid_reg, ray_last_reg, done_reg, cfg_err_reg;
    logic [3*DIR_W-1:0] ray_dir_reg;
    logic [IDX_W-1:0]   ray_index_reg;
    logic [DIR_W-1:0]   dir_lane [3];

    assign area   = (2*DIM_W)'(img_w) * (2*DIM_W)'(img_h);
    assign cfg_ok = (num_cores != '0) && (num_cores <= CORE_W'(MAX_CORES)) &&
                    (DIM_W'(num_cores) <= img_w) && (core_id < num_cores) &&
                    (img_w != '0) && (img_h != '0) && ((2*DIM_W)'(core_id) < area);

    // abort dominates start, so a simultaneous pair neither loads nor errors.
    assign accept = (state_reg == IDLE) && start && !abort && cfg_ok;
    assign reject = (state_reg == IDLE) && start && !abort && !cfg_ok;
    assign adv    = (state_reg != IDLE) && (!ray_valid_reg || ray_ready);
    assign finish = (state_reg == RUN) && ray_valid_reg && ray_ready && ray_last_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (finish) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    ray_pixel_counter #(
        .DIM_W  (DIM_W),
        .IDX_W  (IDX_W),
        .CORE_W (CORE_W)
    ) u_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (accept),
        .clear     (abort),
        .en        (adv),
        .core_id   (core_id),
        .num_cores (nc_reg),
        .img_w     (w_reg),
        .total     (total_reg),
        .pix_valid (pix_valid),
        .x         (pix_x),
        .y         (pix_y),
        .idx       (pix_idx),
        .last      (pix_last)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic signed [PROD_W-1:0] prod_r, prod_u;
            logic signed [SUM_W-1:0]  lane_sum;

            assign prod_r   = PROD_W'(get_lane(right_reg, gi)) * PROD_W'(dx_reg);
            assign prod_u   = PROD_W'(get_lane(up_reg, gi)) * PROD_W'(dy_reg);
            assign lane_sum = SUM_W'(prod_r) + SUM_W'(prod_u) + SUM_W'(get_lane(fwd_reg, gi));
            assign dir_lane[gi] = lane_sum[DIR_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            w_reg         <= '0;
            h_reg         <= '0;
            nc_reg        <= '0;
            total_reg     <= '0;
            fwd_reg       <= '0;
            right_reg     <= '0;
            up_reg        <= '0;
            s1_valid_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            s1_idx_reg    <= '0;
            dx_reg        <= '0;
            dy_reg        <= '0;
            ray_valid_reg <= 1'b0;
            ray_last_reg  <= 1'b0;
            ray_dir_reg   <= '0;
            ray_index_reg <= '0;
            done_reg      <= 1'b0;
            cfg_err_reg   <= 1'b0;
        end else begin
            done_reg    <= finish && !abort;
            cfg_err_reg <= reject;
            if (accept) begin
                w_reg        <= img_w;
                h_reg        <= img_h;
                nc_reg       <= num_cores;
                total_reg    <= IDX_W'(area);
                fwd_reg      <= unpack_vec(cam_fwd);
                right_reg    <= unpack_vec(cam_right);
                up_reg       <= unpack_vec(cam_up);
                s1_valid_reg <= 1'b0;
            end else if (abort || finish) begin
                s1_valid_reg  <= 1'b0;
                ray_valid_reg <= 1'b0;
                ray_last_reg  <= 1'b0;
            end else if (adv) begin
                // Whole pipe advances together; a stalled output freezes every stage.
                s1_valid_reg  <= pix_valid;
                s1_last_reg   <= pix_last;
                s1_idx_reg    <= pix_idx;
                dx_reg        <= $signed({1'b0, pix_x}) - $signed({1'b0, w_reg >> 1});
                dy_reg        <= $signed({1'b0, h_reg >> 1}) - $signed({1'b0, pix_y});
                ray_valid_reg <= s1_valid_reg;
                ray_last_reg  <= s1_valid_reg && s1_last_reg;
                ray_index_reg <= s1_idx_reg;
                ray_dir_reg   <= {dir_lane[2], dir_lane[1], dir_lane[0]};
            end
        end
    end

    assign ray_valid = ray_valid_reg;
    assign ray_last  = ray_last_reg;
    assign ray_dir   = ray_dir_reg;
    assign ray_index = ray_index_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_ray_gen_stream.sv
// Self-checking bench for ray_gen_stream: table of frames scored against a
// div/mod reference model, plus abort, reset and config-error sequences.
module tb_ray_gen_stream;

    localparam int CW     = 11;
    localparam int DW     = 13;
    localparam int OW     = 32;
    localparam int IW     = 32;
    localparam int CORE_W = 4;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              abort;
    logic [3*CW-1:0]   cam_fwd, cam_right, cam_up;
    logic [DW-1:0]     img_w, img_h;
    logic [CORE_W-1:0] core_id, num_cores;
    logic              ray_valid, ray_ready, ray_last, busy, done, cfg_err;
    logic [3*OW-1:0]   ray_dir;
    logic [IW-1:0]     ray_index;

    typedef struct packed {
        logic [IW-1:0]   idx;
        logic [3*OW-1:0] dir;
        logic            last;
    } ray_t;

    typedef struct {
        int w, h, nc, cid;
        int r[3];
        int u[3];
        int fw[3];
        bit rnd;
        bit err;
    } frame_t;

    ray_t   exp_q[$];
    frame_t frames[12];
    int     n_cmp = 0;
    int     n_bad = 0;

    ray_gen_stream dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .cam_fwd   (cam_fwd),
        .cam_right (cam_right),
        .cam_up    (cam_up),
        .img_w     (img_w),
        .img_h     (img_h),
        .core_id   (core_id),
        .num_cores (num_cores),
        .ray_valid (ray_valid),
        .ray_ready (ray_ready),
        .ray_dir   (ray_dir),
        .ray_index (ray_index),
        .ray_last  (ray_last),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input bit ok, input string name, input logic [159:0] got, input logic [159:0] req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    function automatic frame_t mkf(input int w, h, nc, cid, rx, ry, rz, ux, uy, uz,
                                   fx, fy, fz, input bit rnd, input bit err);
        frame_t m;
        m.w = w; m.h = h; m.nc = nc; m.cid = cid;
        m.r[0] = rx; m.r[1] = ry; m.r[2] = rz;
        m.u[0] = ux; m.u[1] = uy; m.u[2] = uz;
        m.fw[0] = fx; m.fw[1] = fy; m.fw[2] = fz;
        m.rnd = rnd; m.err = err;
        return m;
    endfunction

    task automatic drive_cfg(input frame_t f);
        img_w     = DW'(f.w);
        img_h     = DW'(f.h);
        num_cores = CORE_W'(f.nc);
        core_id   = CORE_W'(f.cid);
        cam_right = {CW'(f.r[2]), CW'(f.r[1]), CW'(f.r[0])};
        cam_up    = {CW'(f.u[2]), CW'(f.u[1]), CW'(f.u[0])};
        cam_fwd   = {CW'(f.fw[2]), CW'(f.fw[1]), CW'(f.fw[0])};
    endtask

    task automatic scramble_cfg();
        img_w = DW'(1); img_h = DW'(1); num_cores = '0; core_id = '0;
        cam_right = '0; cam_up = '0; cam_fwd = '0;
    endtask

    // Reference uses plain div/mod so it shares nothing with the incremental walker.
    task automatic push_expected(input frame_t f);
        ray_t e;
        int x, y, dx, dy, d;
        exp_q.delete();
        for (int i = f.cid; i < f.w * f.h; i += f.nc) begin
            x = i % f.w;
            y = i / f.w;
            dx = x - f.w / 2;
            dy = f.h / 2 - y;
            e.idx = IW'(i);
            for (int c = 0; c < 3; c++) begin
                d = f.r[c] * dx + f.u[c] * dy + f.fw[c];
                e.dir[c*OW +: OW] = OW'(d);
            end
            e.last = (i + f.nc >= f.w * f.h);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_frame(input frame_t f);
        ray_t cur, prev, e;
        bit   got_last, prev_stall;
        int   cyc;
        push_expected(f);
        drive_cfg(f);
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble_cfg();
        chk(busy && !ray_valid, "load_state", {busy, ray_valid}, 2'b10);
        tick();
        chk(!ray_valid, "latency_1", ray_valid, 0);
        tick();
        chk(ray_valid, "latency_2", ray_valid, 1);
        got_last = 0; prev_stall = 0; cyc = 0; prev = '0;
        while (!got_last && cyc < 4000) begin
            ray_ready = f.rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            cur = {ray_index, ray_dir, ray_last};
            if (prev_stall) chk(ray_valid && cur == prev, "stall_hold", cur, prev);
            if (done) chk(0, "early_done", done, 0);
            if (ray_valid && ray_ready) begin
                if (exp_q.size() == 0) begin
                    chk(0, "extra_ray", cur, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(cur == e, "ray", cur, e);
                end
                $display("ray idx=%0d dir=(%0d,%0d,%0d) last=%0d", ray_index,
                         $signed(ray_dir[OW-1:0]), $signed(ray_dir[2*OW-1:OW]),
                         $signed(ray_dir[3*OW-1:2*OW]), ray_last);
                if (ray_last) got_last = 1;
            end
            prev_stall = ray_valid && !ray_ready;
            prev = cur;
            tick();
            cyc++;
        end
        chk(got_last, "last_seen", got_last, 1);
        chk(done && !ray_valid && !busy, "done_pulse", {done, ray_valid, busy}, 3'b100);
        chk(exp_q.size() == 0, "missing_rays", exp_q.size(), 0);
        ray_ready = 1'b1;
        tick();
        chk(!done, "done_one_cycle", done, 0);
    endtask

    task automatic run_err(input frame_t f);
        drive_cfg(f);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk(cfg_err && !busy && !ray_valid, "cfg_err_pulse", {cfg_err, busy, ray_valid}, 3'b100);
        $display("cfg w=%0d h=%0d nc=%0d cid=%0d cfg_err=%0d", f.w, f.h, f.nc, f.cid, cfg_err);
        tick();
        chk(!cfg_err && !busy && !ray_valid, "cfg_err_after", {cfg_err, busy, ray_valid}, 3'b000);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; ray_ready = 1'b1;
        scramble_cfg();
        frames[0]  = mkf(4, 2, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 5, 0, 0);
        frames[1]  = mkf(4, 2, 2, 1, 1, 0, 0, 0, 1, 0, 0, 0, 5, 0, 0);
        frames[2]  = mkf(3, 3, 2, 1, 2, -1, 3, -4, 5, 1, 7, -8, 100, 1, 0);
        frames[3]  = mkf(5, 3, 3, 2, -1024, 1023, -7, 511, -512, 3, 100, -200, 300, 1, 0);
        frames[4]  = mkf(7, 4, 7, 6, 3, 3, 3, -2, -2, -2, 0, 1, -1, 1, 0);
        frames[5]  = mkf(13, 5, 4, 0, -1000, -999, 1000, 1023, -1024, 5, -1024, 1023, 0, 1, 0);
        frames[6]  = mkf(4, 2, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 5, 0, 1);
        frames[7]  = mkf(4, 2, 2, 2, 1, 0, 0, 0, 1, 0, 0, 0, 5, 0, 1);
        frames[8]  = mkf(16, 2, 9, 0, 1, 0, 0, 0, 1, 0, 0, 0, 5, 0, 1);
        frames[9]  = mkf(3, 2, 4, 0, 1, 0, 0, 0, 1, 0, 0, 0, 5, 0, 1);
        frames[10] = mkf(0, 2, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 5, 0, 1);
        frames[11] = mkf(4, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 5, 0, 1);

        tick();
        tick();
        chk({ray_valid, ray_last, busy, done, cfg_err} == 5'b0 && ray_dir == '0 && ray_index == '0,
            "reset_state", {ray_valid, ray_last, busy, done, cfg_err, ray_index}, 0);
        reset_n = 1'b1;
        tick();

        for (int t = 0; t < 12; t++) begin
            if (frames[t].err) run_err(frames[t]);
            else run_frame(frames[t]);
        end

        // start and abort together in IDLE: abort wins.
        drive_cfg(frames[0]);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk(!busy && !cfg_err, "start_abort_idle", {busy, cfg_err}, 0);
        tick();
        chk(!busy && !ray_valid, "start_abort_idle2", {busy, ray_valid}, 0);

        // Abort while stalled on a valid ray, then a fresh frame.
        ray_ready = 1'b0;
        drive_cfg(frames[0]);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk(ray_valid && busy, "abort_pre", {ray_valid, busy}, 2'b11);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk(!ray_valid && !busy, "abort_idle", {ray_valid, busy}, 0);
        tick();
        chk(!done && !ray_valid, "abort_no_done", {done, ray_valid}, 0);
        ray_ready = 1'b1;
        run_frame(frames[2]);

        // Reset in mid-frame discards the in-flight ray.
        ray_ready = 1'b0;
        drive_cfg(frames[3]);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        reset_n = 1'b0;
        tick();
        chk({ray_valid, ray_last, busy, done} == 4'b0 && ray_dir == '0 && ray_index == '0,
            "midframe_reset", {ray_valid, ray_last, busy, done, ray_index}, 0);
        reset_n = 1'b1;
        ray_ready = 1'b1;
        tick();
        run_frame(frames[1]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
